// File: rtl/spi_pkg.sv
// Shared encodings for the SPI register-file peripheral: R/W bit values,
// frame FSM states and the frame-length helper.
package spi_pkg;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WAIT_CS
    } spi_state_t;

    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous SPI pin, with one extra flop
// to detect rising/falling edges of the synchronised level.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {SYNC_STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign q    = sync[SYNC_STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 peripheral giving an external controller read/write access to a
// bank of NUM_REGS registers; writes commit only on a clean nCS release.
module spi_regfile_periph
    import spi_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       ncs,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic                       wr_stb,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    logic sclk_rise, sclk_fall, ncs_s, ncs_rise, ncs_fall, copi_s;
    logic unused_sclk_lvl;
    logic [1:0] unused_copi_edges;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk),
        .q(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    // nCS idles high, so reset its synchroniser high to avoid a false frame start
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d(ncs),
        .q(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d(copi),
        .q(copi_s), .rise(unused_copi_edges[0]), .fall(unused_copi_edges[1])
    );

    spi_state_t          state, state_n;
    logic [CNT_W-1:0]    bit_cnt;
    logic [FRAME_W-1:0]  shift_in;
    logic [DATA_W-1:0]   rd_shift;
    logic                overlong;

    logic                bit_in;
    logic [ADDR_W-1:0]   frame_addr, rd_addr;
    logic [DATA_W-1:0]   frame_data, rd_word;
    logic                frame_rw, wr_hit, load_rd, commit, discard;

    assign bit_in     = sclk_rise & ~ncs_s;
    assign frame_addr = shift_in[DATA_W +: ADDR_W];
    assign frame_data = shift_in[DATA_W-1:0];
    assign frame_rw   = shift_in[FRAME_W-1];
    // on the last address bit the R/W bit sits at ADDR_W-1 and copi completes the address
    assign rd_addr    = {shift_in[ADDR_W-2:0], copi_s};

    always_comb begin
        rd_word = '0;
        wr_hit  = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_addr == ADDR_W'(k))
                rd_word = reg_q[k*DATA_W +: DATA_W];
            if (frame_addr == ADDR_W'(k))
                wr_hit = 1'b1;
        end
    end

    assign load_rd = bit_in && (state == ST_ADDR) && (bit_cnt == CNT_W'(ADDR_W))
                     && (shift_in[ADDR_W-1] == RW_READ);
    assign commit  = (state == ST_WAIT_CS) && !overlong && (frame_rw == RW_WRITE) && wr_hit;
    assign discard = (state == ST_ADDR) || (state == ST_DATA)
                     || ((state == ST_WAIT_CS) && overlong);

    always_comb begin
        state_n = state;
        if (ncs_fall) begin
            state_n = ST_ADDR;
        end else if (ncs_rise) begin
            state_n = ST_IDLE;
        end else if (bit_in) begin
            case (state)
                ST_ADDR: if (bit_cnt == CNT_W'(ADDR_W))      state_n = ST_DATA;
                ST_DATA: if (bit_cnt == CNT_W'(FRAME_W - 1)) state_n = ST_WAIT_CS;
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_in  <= '0;
            rd_shift  <= '0;
            overlong  <= 1'b0;
            cipo      <= 1'b0;
            cipo_oe   <= 1'b0;
            reg_q     <= '0;
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            wr_stb    <= 1'b0;
            frame_err <= 1'b0;
            if (ncs_fall) begin
                bit_cnt  <= '0;
                shift_in <= '0;
                rd_shift <= '0;
                overlong <= 1'b0;
                cipo     <= 1'b0;
                cipo_oe  <= 1'b0;
            end else if (ncs_rise) begin
                bit_cnt   <= '0;
                cipo      <= 1'b0;
                cipo_oe   <= 1'b0;
                frame_err <= discard;
                if (commit) begin
                    for (int k = 0; k < NUM_REGS; k++)
                        if (frame_addr == ADDR_W'(k))
                            reg_q[k*DATA_W +: DATA_W] <= frame_data;
                    wr_stb  <= 1'b1;
                    wr_addr <= frame_addr;
                end
            end else if (!ncs_s) begin
                if (sclk_rise) begin
                    if (state == ST_ADDR || state == ST_DATA)
                        shift_in <= {shift_in[FRAME_W-2:0], copi_s};
                    if (state != ST_IDLE && bit_cnt != CNT_W'(FRAME_W))
                        bit_cnt <= bit_cnt + 1'b1;
                    if (state == ST_WAIT_CS)
                        overlong <= 1'b1;
                    if (load_rd) begin
                        rd_shift <= rd_word;
                        cipo     <= rd_word[DATA_W-1];
                        cipo_oe  <= 1'b1;
                    end
                // the fall right after the load precedes the MSB's sampling rise, so it holds
                end else if (sclk_fall && state == ST_DATA && cipo_oe
                             && bit_cnt != CNT_W'(ADDR_W + 1)) begin
                    rd_shift <= {rd_shift[DATA_W-2:0], 1'b0};
                    cipo     <= rd_shift[DATA_W-2];
                end
            end
        end
    end

endmodule
